// File: rtl/global_pulse_mon_if.sv
// rtl/global_pulse_mon_if.sv - pulse monitor stimulus/result bundle with master/slave views
interface global_pulse_mon_if;
    logic        GlobalPulse;
    logic [3:0]  ExpWidth;
    logic        ExpCheckEn;
    logic        Busy;
    logic        WidthValid;
    logic [10:0] WidthCnt;
    logic [3:0]  WidthCode;
    logic        CodeErr;
    logic        Overflow;
    logic        Mismatch;
    logic [15:0] PulseCount;

    modport master (
        output GlobalPulse, ExpWidth, ExpCheckEn,
        input  Busy, WidthValid, WidthCnt, WidthCode, CodeErr, Overflow, Mismatch, PulseCount
    );

    modport slave (
        input  GlobalPulse, ExpWidth, ExpCheckEn,
        output Busy, WidthValid, WidthCnt, WidthCode, CodeErr, Overflow, Mismatch, PulseCount
    );
endinterface

// File: rtl/global_pulse_mon.sv
// rtl/global_pulse_mon.sv - measures GlobalPulse high time and reports width code/check results
module global_pulse_mon (
    input  logic               clk,
    input  logic               Reset_b,
    global_pulse_mon_if.slave  bus
);
    typedef enum logic {ST_IDLE, ST_HIGH} state_t;

    state_t      r_state;
    logic        r_gp_prev;
    logic [10:0] r_cnt;
    logic        r_ovf_flag;
    logic        r_busy;
    logic        r_valid;
    logic [10:0] r_width_cnt;
    logic [3:0]  r_width_code;
    logic        r_code_err;
    logic        r_overflow;
    logic        r_mismatch;
    logic [15:0] r_pulse_count;

    logic        w_rise;
    logic        w_cnt_sat;
    logic        w_pow2;
    logic [3:0]  w_code;
    logic        w_code_err;
    logic [3:0]  w_exp_code;
    logic        w_mismatch;

    assign w_rise    = bus.GlobalPulse && !r_gp_prev;
    assign w_cnt_sat = &r_cnt;

    // Exactly one of the ten legal widths can match, so the loop acts as a one-hot log2.
    always_comb begin
        w_code = 4'hF;
        w_pow2 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (r_cnt == (11'd1 << i)) begin
                w_code = 4'(i);
                w_pow2 = 1'b1;
            end
        end
    end

    assign w_code_err = !w_pow2 || r_ovf_flag;
    assign w_exp_code = (bus.ExpWidth > 4'd9) ? 4'd9 : bus.ExpWidth;
    assign w_mismatch = bus.ExpCheckEn && (w_code_err || (w_code != w_exp_code));

    // GpPrev resets high so a pulse already asserted at reset release is not a rising edge.
    always_ff @(posedge clk or negedge Reset_b) begin
        if (!Reset_b) begin
            r_state       <= ST_IDLE;
            r_gp_prev     <= 1'b1;
            r_cnt         <= '0;
            r_ovf_flag    <= 1'b0;
            r_busy        <= 1'b0;
            r_valid       <= 1'b0;
            r_width_cnt   <= '0;
            r_width_code  <= '0;
            r_code_err    <= 1'b0;
            r_overflow    <= 1'b0;
            r_mismatch    <= 1'b0;
            r_pulse_count <= '0;
        end else begin
            r_gp_prev <= bus.GlobalPulse;
            r_valid   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_state    <= ST_HIGH;
                        r_cnt      <= 11'd1;
                        r_ovf_flag <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (bus.GlobalPulse) begin
                        if (w_cnt_sat) begin
                            r_ovf_flag <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 11'd1;
                        end
                    end else begin
                        r_state       <= ST_IDLE;
                        r_busy        <= 1'b0;
                        r_valid       <= 1'b1;
                        r_width_cnt   <= r_cnt;
                        r_width_code  <= w_code;
                        r_code_err    <= w_code_err;
                        r_overflow    <= r_ovf_flag;
                        r_mismatch    <= w_mismatch;
                        r_pulse_count <= r_pulse_count + 16'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.Busy       = r_busy;
    assign bus.WidthValid = r_valid;
    assign bus.WidthCnt   = r_width_cnt;
    assign bus.WidthCode  = r_width_code;
    assign bus.CodeErr    = r_code_err;
    assign bus.Overflow   = r_overflow;
    assign bus.Mismatch   = r_mismatch;
    assign bus.PulseCount = r_pulse_count;
endmodule

// File: doc/global_pulse_mon.md
GLOBAL_PULSE_MON -- requirements
Module: global_pulse_mon

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port Reset_b  input  1  asynchronous reset, active low; assertion clears all state immediately, independent of clk.
REQ-003 SHALL have port GlobalPulse  input  1  monitored pulse, synchronous to clk.
REQ-004 SHALL have port ExpWidth  input  4  expected width code; widths 0..8 mean 2^ExpWidth cycles, widths 9..15 mean 512 cycles.
REQ-005 SHALL have port ExpCheckEn  input  1  enables the expected-width comparison.
REQ-006 SHALL have port Busy  output  1  high while a pulse measurement is in progress.
REQ-007 SHALL have port WidthValid  output  1  one-cycle strobe; measurement result is valid on this cycle.
REQ-008 SHALL have port WidthCnt  output  11  measured high time in clk cycles.
REQ-009 SHALL have port WidthCode  output  4  decoded width code, 0..9, or 4'hF when undecodable.
REQ-010 SHALL have port CodeErr  output  1  measured width is not one of 1,2,4,...,512.
REQ-011 SHALL have port Overflow  output  1  measured width saturated at 2047.
REQ-012 SHALL have port Mismatch  output  1  checked result differs from the expected width.
REQ-013 SHALL have port PulseCount  output  16  number of completed measurements.

Function
REQ-014 SHALL register GlobalPulse into a previous-sample flop (GpPrev) each cycle.
REQ-015 SHALL implement the FSM states IDLE and HIGH.
REQ-016 In IDLE, when GlobalPulse=1 and GpPrev=0 (rising edge), the FSM SHALL go to HIGH, load the counter with 1, and set Busy=1 on the following cycle.
REQ-017 In IDLE, a level-high GlobalPulse without a rising edge SHALL be ignored.
REQ-018 In HIGH, when GlobalPulse=1 the counter SHALL increment, saturating at 2047.
REQ-019 On a saturated increment the block SHALL set an internal overflow flag, which clears only when the next measurement starts.
REQ-020 In HIGH, the first cycle with GlobalPulse=0 SHALL return the FSM to IDLE.
REQ-021 On that same clock edge the block SHALL register WidthValid=1, WidthCnt=counter, WidthCode, CodeErr, Overflow and Mismatch; WidthValid is therefore asserted in the cycle after the first low sample.
REQ-022 WidthValid SHALL be high for exactly one cycle per measurement.
REQ-023 WidthCnt, WidthCode, CodeErr, Overflow and Mismatch SHALL hold their values until the next WidthValid.
REQ-024 WidthCode SHALL equal log2(counter) when counter is a power of two in the range 1..512; otherwise WidthCode SHALL be 4'hF and CodeErr SHALL be 1.
REQ-025 Overflow=1 SHALL force CodeErr=1.
REQ-026 Mismatch SHALL be registered as ExpCheckEn AND (CodeErr OR WidthCode != min(ExpWidth,9)), using ExpWidth and ExpCheckEn sampled on the reporting edge.
REQ-027 When ExpCheckEn=0, Mismatch SHALL be 0.
REQ-028 PulseCount SHALL increment by 1 on each reporting edge and wrap from 16'hFFFF to 0 with no flag.
REQ-029 A new rising edge SHALL be accepted on the cycle immediately after the reporting edge; back-to-back pulses separated by one low cycle are both measured.
REQ-030 A pulse longer than 2047 cycles SHALL report WidthCnt=2047, Overflow=1, CodeErr=1 and WidthCode=4'hF.

Reset
REQ-031 While Reset_b=0, the block SHALL force: state=IDLE, counter=0, Busy=0, WidthValid=0, WidthCnt=0, WidthCode=0, CodeErr=0, Overflow=0, Mismatch=0, PulseCount=0.
REQ-032 While Reset_b=0, GpPrev SHALL be forced to 1, so a pulse already high at reset release is not measured; measurement begins only at the next genuine rising edge.
REQ-033 Reset asserted mid-pulse SHALL abort the measurement with no WidthValid strobe.

Verification
REQ-034 Bench SHALL cover: GlobalPulse high for 16 cycles with ExpWidth=4 and ExpCheckEn=1 -> one WidthValid, WidthCnt=16, WidthCode=4, CodeErr=0, Mismatch=0, PulseCount=1.
REQ-035 Bench SHALL cover: high for 512 cycles with ExpWidth=12 and ExpCheckEn=1 -> WidthCnt=512, WidthCode=9, Mismatch=0.
REQ-036 Bench SHALL cover: high for 5 cycles with ExpWidth=2 and ExpCheckEn=1 -> WidthCnt=5, WidthCode=4'hF, CodeErr=1, Mismatch=1; the same pulse with ExpCheckEn=0 -> Mismatch=0.
REQ-037 Bench SHALL cover: high for 3000 cycles -> WidthCnt=2047, Overflow=1, CodeErr=1, and WidthValid in the cycle after the first low sample.
REQ-038 Bench SHALL cover: pulses of 1 cycle and 2 cycles separated by one low cycle -> two strobes with WidthCode=0 and then 1, and PulseCount=2.
REQ-039 Bench SHALL cover: Reset_b pulsed low mid-pulse and released while GlobalPulse is still high -> no strobe for that pulse, all outputs 0, and the next clean 8-cycle pulse reports WidthCode=3 with PulseCount=1.
